// File: rtl/c2h_stream_arbiter.sv
// rtl/c2h_stream_arbiter.sv - round-robin packet arbiter of two AXI-Stream sources onto one C2H channel
`timescale 1ns/1ps
module c2h_stream_arbiter #(
  parameter int DATA_W        = 256,
  parameter int MAX_PKT_BEATS = 1024,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   s0_tdata,
  input  logic [DATA_W/8-1:0] s0_tkeep,
  input  logic                s0_tlast,
  input  logic                s0_tvalid,
  output logic                s0_tready,
  input  logic [DATA_W-1:0]   s1_tdata,
  input  logic [DATA_W/8-1:0] s1_tkeep,
  input  logic                s1_tlast,
  input  logic                s1_tvalid,
  output logic                s1_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [CNT_W-1:0]    pkt_cnt0,
  output logic [CNT_W-1:0]    pkt_cnt1,
  output logic                oversize_err,
  input  logic                err_clr
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int ENT_W  = DATA_W + KEEP_W + 1;
  localparam int BC_W   = $clog2(MAX_PKT_BEATS) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_GNT0, ST_GNT1} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_grant;
  logic                r_s0_tready;
  logic                r_s1_tready;
  logic [1:0]          r_count;
  logic [1:0]          w_next_count;
  logic                r_m_tvalid;
  logic [ENT_W-1:0]    r_ent0;
  logic [ENT_W-1:0]    r_ent1;
  logic [ENT_W-1:0]    w_in_ent;
  logic [BC_W-1:0]     r_beat_cnt;
  logic [CNT_W-1:0]    r_pkt_cnt0;
  logic [CNT_W-1:0]    r_pkt_cnt1;
  logic                r_oversize;
  logic                w_acc0;
  logic                w_acc1;
  logic                w_acc;
  logic                w_in_last;
  logic                w_pop;
  logic                w_pkt_idle;
  logic                w_ovf_set;

  // tready is only ever high on the granted source, so the accept strobes are exclusive
  assign w_acc0       = s0_tvalid & r_s0_tready;
  assign w_acc1       = s1_tvalid & r_s1_tready;
  assign w_acc        = w_acc0 | w_acc1;
  assign w_in_last    = w_acc1 ? s1_tlast : s0_tlast;
  assign w_in_ent     = w_acc1 ? {s1_tdata, s1_tkeep, s1_tlast} : {s0_tdata, s0_tkeep, s0_tlast};
  assign w_pop        = r_m_tvalid & m_tready;
  assign w_next_count = r_count + {1'b0, w_acc} - {1'b0, w_pop};
  assign w_pkt_idle   = (r_beat_cnt == '0);
  assign w_ovf_set    = w_acc & (r_beat_cnt == BC_W'(MAX_PKT_BEATS));

  // Next grant: round-robin at packet ends; a granted source that sits idle between
  // packets yields to a waiting peer, but a mid-packet tvalid drop keeps the grant.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (s0_tvalid && s1_tvalid) w_next_state = r_last_grant ? ST_GNT0 : ST_GNT1;
        else if (s0_tvalid)         w_next_state = ST_GNT0;
        else if (s1_tvalid)         w_next_state = ST_GNT1;
      end
      ST_GNT0: begin
        if (w_acc0 && s0_tlast)
          w_next_state = s1_tvalid ? ST_GNT1 : (s0_tvalid ? ST_GNT0 : ST_IDLE);
        else if (w_pkt_idle && !s0_tvalid && s1_tvalid)
          w_next_state = ST_GNT1;
      end
      ST_GNT1: begin
        if (w_acc1 && s1_tlast)
          w_next_state = s0_tvalid ? ST_GNT0 : (s1_tvalid ? ST_GNT1 : ST_IDLE);
        else if (w_pkt_idle && !s1_tvalid && s0_tvalid)
          w_next_state = ST_GNT0;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Grant state, last-granted source and registered source readies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_s0_tready  <= 1'b0;
      r_s1_tready  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_s0_tready <= (w_next_state == ST_GNT0) && (w_next_count < 2'd2);
      r_s1_tready <= (w_next_state == ST_GNT1) && (w_next_count < 2'd2);
      if (w_acc0 && s0_tlast)      r_last_grant <= 1'b0;
      else if (w_acc1 && s1_tlast) r_last_grant <= 1'b1;
    end
  end

  // Two-entry skid FIFO; entry 0 drives m_* directly and only moves on a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 2'd0;
      r_m_tvalid <= 1'b0;
      r_ent0     <= '0;
      r_ent1     <= '0;
    end else begin
      r_count    <= w_next_count;
      r_m_tvalid <= (w_next_count != 2'd0);
      if (w_pop) begin
        if (r_count == 2'd2) r_ent0 <= r_ent1;
        else if (w_acc)      r_ent0 <= w_in_ent;
      end else if (w_acc && r_count == 2'd0) begin
        r_ent0 <= w_in_ent;
      end
      if (w_acc && !w_pop && r_count == 2'd1) r_ent1 <= w_in_ent;
    end
  end

  // Beat count of the packet in flight, saturating at the limit so it cannot wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_acc) begin
      if (w_in_last)                                    r_beat_cnt <= '0;
      else if (r_beat_cnt != BC_W'(MAX_PKT_BEATS))      r_beat_cnt <= r_beat_cnt + BC_W'(1);
    end
  end

  // Sticky oversize flag (clear wins) and wrapping per-source packet counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oversize <= 1'b0;
      r_pkt_cnt0 <= '0;
      r_pkt_cnt1 <= '0;
    end else begin
      if (err_clr)        r_oversize <= 1'b0;
      else if (w_ovf_set) r_oversize <= 1'b1;
      if (w_acc0 && s0_tlast) r_pkt_cnt0 <= r_pkt_cnt0 + CNT_W'(1);
      if (w_acc1 && s1_tlast) r_pkt_cnt1 <= r_pkt_cnt1 + CNT_W'(1);
    end
  end

  assign s0_tready    = r_s0_tready;
  assign s1_tready    = r_s1_tready;
  assign m_tvalid     = r_m_tvalid;
  assign m_tdata      = r_ent0[ENT_W-1:KEEP_W+1];
  assign m_tkeep      = r_ent0[KEEP_W:1];
  assign m_tlast      = r_ent0[0];
  assign pkt_cnt0     = r_pkt_cnt0;
  assign pkt_cnt1     = r_pkt_cnt1;
  assign oversize_err = r_oversize;

endmodule

// File: tb/tb_c2h_stream_arbiter.sv
// tb/tb_c2h_stream_arbiter.sv - randomized self-checking bench for c2h_stream_arbiter
`timescale 1ns/1ps
module tb_c2h_stream_arbiter;

  localparam int DATA_W = 256;
  localparam int KEEP_W = DATA_W / 8;
  localparam int MAXB   = 1024;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] s0_tdata = '0, s1_tdata = '0;
  logic [KEEP_W-1:0] s0_tkeep = '0, s1_tkeep = '0;
  logic              s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic              s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic              s0_tready, s1_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic              m_tlast, m_tvalid;
  logic              m_tready = 1'b1;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;
  logic              oversize_err;
  logic              err_clr = 1'b0;

  c2h_stream_arbiter #(.DATA_W(DATA_W), .MAX_PKT_BEATS(MAXB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
    .oversize_err(oversize_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    logic              l;
  } beat_t;

  beat_t q0[$], q1[$], exp_q[$], got_q[$];
  int n_tests = 0, n_fail = 0;
  int in_cnt, out_cnt, first_acc, first_out, last_out;
  int v_valid, v_ready, v_stable, saw_full;
  bit mon_done;

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    for (int i = 0; i < DATA_W / 32; i++) b.d[i*32 +: 32] = $urandom();
    b.k = $urandom();
    b.l = last;
    return b;
  endfunction

  task automatic add_pkt(input int src, input int len);
    for (int i = 0; i < len; i++) begin
      if (src == 0) q0.push_back(rand_beat(i == len - 1));
      else          q1.push_back(rand_beat(i == len - 1));
    end
  endtask

  // Packet-level reference: whole packets, round-robin while both sources have
  // work (s0 first after reset), then the remainder of whichever is left.
  task automatic build_exp();
    beat_t c0[$], c1[$];
    beat_t b;
    int last = 1;
    int src;
    c0 = q0;
    c1 = q1;
    exp_q.delete();
    while (c0.size() > 0 || c1.size() > 0) begin
      if (c0.size() > 0 && c1.size() > 0) src = (last == 1) ? 0 : 1;
      else                                src = (c0.size() > 0) ? 0 : 1;
      do begin
        if (src == 0) b = c0.pop_front();
        else          b = c1.pop_front();
        exp_q.push_back(b);
      end while (!b.l);
      last = src;
    end
  endtask

  function automatic int beat_mismatches();
    int bad;
    int n;
    bad = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    n   = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l) bad++;
    return bad;
  endfunction

  task automatic drive_src(input int id, input int gap_pct, input int lim);
    beat_t b;
    bit vld = 0, acc, in_pkt = 0;
    while (((id == 0) ? q0.size() : q1.size()) > 0 && cyc < lim) begin
      if (id == 0) b = q0[0];
      else         b = q1[0];
      if (!vld) vld = !(in_pkt && ($urandom_range(0, 99) < gap_pct));
      if (id == 0) begin
        s0_tdata = b.d; s0_tkeep = b.k; s0_tlast = b.l; s0_tvalid = vld;
      end else begin
        s1_tdata = b.d; s1_tkeep = b.k; s1_tlast = b.l; s1_tvalid = vld;
      end
      @(negedge clk);
      acc = vld && ((id == 0) ? s0_tready : s1_tready);
      if (acc && first_acc < 0) first_acc = cyc;
      @(posedge clk);
      #1;
      if (acc) begin
        if (id == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
        in_cnt++;
        in_pkt = !b.l;
        vld    = 0;
      end
    end
    if (id == 0) s0_tvalid = 1'b0;
    else         s1_tvalid = 1'b0;
  endtask

  task automatic sink(input int mode, input int lim);
    m_tready = 1'b1;
    while (!mon_done && cyc < lim) begin
      @(posedge clk);
      #1;
      if (mode == 1)      m_tready = ~m_tready;
      else if (mode == 2) m_tready = 1'($urandom_range(0, 1));
    end
    m_tready = 1'b1;
  endtask

  // Collects output beats and tallies protocol observations against the occupancy
  // implied by beats accepted in minus beats taken out.
  task automatic monitor(input int n_exp, input int lim);
    logic [DATA_W-1:0] pd;
    logic [KEEP_W-1:0] pk;
    logic              pl;
    bit prev_stall = 0;
    int occ;
    beat_t b;
    while (got_q.size() < n_exp && cyc < lim) begin
      @(negedge clk);
      occ = in_cnt - out_cnt;
      if (m_tvalid !== (occ != 0)) v_valid++;
      if (occ == 2) begin
        saw_full++;
        if (s0_tready !== 1'b0 || s1_tready !== 1'b0) v_ready++;
      end
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== pd || m_tkeep !== pk || m_tlast !== pl)) v_stable++;
      if (m_tvalid && m_tready) begin
        b.d = m_tdata; b.k = m_tkeep; b.l = m_tlast;
        got_q.push_back(b);
        out_cnt++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      prev_stall = m_tvalid && !m_tready;
      pd = m_tdata; pk = m_tkeep; pl = m_tlast;
    end
    mon_done = 1;
  endtask

  task automatic run_traffic(input int mode, input int gap_pct, input int budget);
    int lim;
    build_exp();
    got_q.delete();
    in_cnt = 0; out_cnt = 0; first_acc = -1; first_out = -1; last_out = -1;
    v_valid = 0; v_ready = 0; v_stable = 0; saw_full = 0; mon_done = 0;
    lim = cyc + budget;
    fork
      drive_src(0, gap_pct, lim);
      drive_src(1, gap_pct, lim);
      monitor(exp_q.size(), lim);
      sink(mode, lim);
    join
  endtask

  task automatic reset_dut();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
    err_clr = 1'b0; m_tready = 1'b1;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({m_tvalid, m_tlast, s0_tready, s1_tready, oversize_err} !== 5'b0 || m_tdata !== '0 || m_tkeep !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b last=%b rdy=%b%b err=%b, expected all 0",
               m_tvalid, m_tlast, s0_tready, s1_tready, oversize_err);
    end
    n_tests++;
    if (pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d, expected 0/0", pkt_cnt0, pkt_cnt1);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({m_tvalid, s0_tready, s1_tready} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got valid=%b rdy=%b%b, expected 0 with no sources", m_tvalid, s0_tready, s1_tready);
    end
  endtask

  task automatic test_single_s0();
    reset_dut();
    add_pkt(0, 4);
    run_traffic(0, 0, 200);
    n_tests++;
    if (beat_mismatches() !== 0) begin
      n_fail++;
      $display("FAIL single_data: %0d bad beats, expected 0", beat_mismatches());
    end
    n_tests++;
    if (first_out !== first_acc + 1) begin
      n_fail++;
      $display("FAIL single_latency: out cycle %0d, expected %0d", first_out, first_acc + 1);
    end
    n_tests++;
    if (last_out - first_out !== 3) begin
      n_fail++;
      $display("FAIL single_b2b: span %0d, expected 3", last_out - first_out);
    end
    n_tests++;
    if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd0) begin
      n_fail++;
      $display("FAIL single_cnt: got %0d/%0d, expected 1/0", pkt_cnt0, pkt_cnt1);
    end
    n_tests++;
    if (v_valid !== 0) begin
      n_fail++;
      $display("FAIL single_tvalid: %0d cycles, expected 0", v_valid);
    end
  endtask

  task automatic test_alternate();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      add_pkt(0, 2);
      add_pkt(1, 2);
    end
    run_traffic(0, 0, 300);
    n_tests++;
    if (beat_mismatches() !== 0) begin
      n_fail++;
      $display("FAIL alt_order: %0d bad beats, expected 0", beat_mismatches());
    end
    n_tests++;
    if (last_out - first_out !== 11) begin
      n_fail++;
      $display("FAIL alt_no_bubble: span %0d, expected 11", last_out - first_out);
    end
    n_tests++;
    if (pkt_cnt0 !== 16'd3 || pkt_cnt1 !== 16'd3) begin
      n_fail++;
      $display("FAIL alt_cnt: got %0d/%0d, expected 3/3", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    add_pkt(1, 8);
    run_traffic(1, 0, 300);
    n_tests++;
    if (beat_mismatches() !== 0) begin
      n_fail++;
      $display("FAIL bp_data: %0d bad beats, expected 0", beat_mismatches());
    end
    n_tests++;
    if (v_stable !== 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d unstable stalls, expected 0", v_stable);
    end
    n_tests++;
    if (saw_full == 0 || v_ready !== 0) begin
      n_fail++;
      $display("FAIL bp_full_ready: full=%0d ready_when_full=%0d, expected >0 and 0", saw_full, v_ready);
    end
    n_tests++;
    if (pkt_cnt1 !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_cnt: got %0d, expected 1", pkt_cnt1);
    end
  endtask

  task automatic test_oversize();
    reset_dut();
    add_pkt(0, MAXB);
    run_traffic(0, 0, 3000);
    n_tests++;
    if (beat_mismatches() !== 0 || oversize_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_at_limit: bad=%0d err=%b, expected 0 and 0", beat_mismatches(), oversize_err);
    end
    add_pkt(0, MAXB + 1);
    run_traffic(0, 0, 3000);
    n_tests++;
    if (beat_mismatches() !== 0) begin
      n_fail++;
      $display("FAIL ovf_data: %0d bad beats, expected 0", beat_mismatches());
    end
    n_tests++;
    if (oversize_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b, expected 1", oversize_err);
    end
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    n_tests++;
    if (oversize_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b, expected 0", oversize_err);
    end
    err_clr = 1'b1;
    add_pkt(0, MAXB + 1);
    run_traffic(0, 0, 3000);
    err_clr = 1'b0;
    n_tests++;
    if (oversize_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr_wins: got %b, expected 0", oversize_err);
    end
    n_tests++;
    if (pkt_cnt0 !== 16'd3) begin
      n_fail++;
      $display("FAIL ovf_cnt: got %0d, expected 3", pkt_cnt0);
    end
  endtask

  task automatic test_reset_midpacket();
    beat_t pk[6];
    int k = 0;
    int lim;
    bit acc;
    reset_dut();
    for (int i = 0; i < 6; i++) pk[i] = rand_beat(i == 5);
    lim = cyc + 100;
    while (k < 3 && cyc < lim) begin
      s0_tdata = pk[k].d; s0_tkeep = pk[k].k; s0_tlast = pk[k].l; s0_tvalid = 1'b1;
      @(negedge clk);
      acc = s0_tready;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    n_tests++;
    if (k !== 3 || m_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: beats=%0d valid=%b, expected 3 and 1", k, m_tvalid);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (m_tvalid !== 1'b0 || s0_tready !== 1'b0 || m_tdata !== '0) begin
      n_fail++;
      $display("FAIL rstmid_flush: valid=%b ready=%b, expected 0 and 0", m_tvalid, s0_tready);
    end
    s0_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_pkt(0, 3);
    add_pkt(1, 2);
    run_traffic(0, 0, 200);
    n_tests++;
    if (beat_mismatches() !== 0) begin
      n_fail++;
      $display("FAIL rstmid_regrant: %0d bad beats, expected 0", beat_mismatches());
    end
    n_tests++;
    if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin
      n_fail++;
      $display("FAIL rstmid_cnt: got %0d/%0d, expected 1/1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_random();
    int n0, n1, mode;
    for (int r = 0; r < 6; r++) begin
      reset_dut();
      n0   = $urandom_range(0, 5);
      n1   = $urandom_range(1, 5);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < n0; i++) add_pkt(0, $urandom_range(1, 8));
      for (int i = 0; i < n1; i++) add_pkt(1, $urandom_range(1, 8));
      run_traffic(mode, 30, 3000);
      n_tests++;
      if (beat_mismatches() !== 0) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: %0d bad beats, expected 0", r, beat_mismatches());
      end
      n_tests++;
      if (v_valid !== 0 || v_ready !== 0 || v_stable !== 0) begin
        n_fail++;
        $display("FAIL rand_proto[%0d]: valid=%0d ready=%0d stable=%0d, expected 0", r, v_valid, v_ready, v_stable);
      end
      n_tests++;
      if (pkt_cnt0 !== 16'(n0) || pkt_cnt1 !== 16'(n1)) begin
        n_fail++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d, expected %0d/%0d", r, pkt_cnt0, pkt_cnt1, n0, n1);
      end
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    int lim;
    reset_dut();
    s1_tdata = '1; s1_tkeep = '1; s1_tlast = 1'b1; s1_tvalid = 1'b1; m_tready = 1'b1;
    lim = cyc + 70000;
    while (n < 65536 && cyc < lim) begin
      @(negedge clk);
      if (n == 65535) begin
        n_tests++;
        if (pkt_cnt1 !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL wrap_max: got %0d, expected 65535", pkt_cnt1);
        end
      end
      if (s1_tready) n++;
    end
    @(posedge clk);
    #1;
    s1_tvalid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (n !== 65536 || pkt_cnt1 !== 16'd0 || pkt_cnt0 !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_zero: beats=%0d cnt1=%0d cnt0=%0d, expected 65536/0/0", n, pkt_cnt1, pkt_cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_single_s0();
    test_alternate();
    test_backpressure();
    test_oversize();
    test_reset_midpacket();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
